// File: rtl/regfile_sb.sv
// Parametrised register file with power-on clear sequencer, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   a1,
  output logic [XLEN-1:0] rd1,
  output logic            busy1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd2,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr_ok;
  logic              iss_ok;

  assign ready  = (state == RUN);
  assign wr_ok  = ready && we && (a3 != '0);
  assign iss_ok = ready && iss_en && (iss_rd != '0);

  // Reset leaves contents alone; the CLEAR walk zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
      if (cnt == AW'(NREGS - 1)) state <= RUN;
      else                       cnt   <= cnt + AW'(1);
    end else begin
      if (wr_ok) begin
        regs[a3] <= wd3;
        busy[a3] <= 1'b0;
      end
      // Issued after the write so a same-register set wins over the clear.
      if (iss_ok) busy[iss_rd] <= 1'b1;
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (ready && (a1 != '0)) begin
      rd1   = regs[a1];
      busy1 = busy[a1];
      if ((BYPASS != 0) && wr_ok && (a3 == a1)) begin
        rd1   = wd3;
        busy1 = (iss_ok && (iss_rd == a1)) ? busy[a1] : 1'b0;
      end
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (ready && (a2 != '0)) begin
      rd2   = regs[a2];
      busy2 = busy[a2];
      if ((BYPASS != 0) && wr_ok && (a3 == a2)) begin
        rd2   = wd3;
        busy2 = (iss_ok && (iss_rd == a2)) ? busy[a2] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3, iss_rd;
  logic [31:0] wd3;
  logic        we, iss_en;

  logic        ready, busy1, busy2;
  logic [31:0] rd1, rd2;
  logic        ready_b, busy1_b, busy2_b;
  logic [31:0] rd1_b, rd2_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a1(a1), .rd1(rd1), .busy1(busy1),
    .a2(a2), .rd2(rd2), .busy2(busy2),
    .we(we), .a3(a3), .wd3(wd3),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ready(ready_b),
    .a1(a1), .rd1(rd1_b), .busy1(busy1_b),
    .a2(a2), .rd2(rd2_b), .busy2(busy2_b),
    .we(we), .a3(a3), .wd3(wd3),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; a3 = '0; wd3 = '0; iss_en = 1'b0; iss_rd = '0;
  endtask

  // ready must stay low for n-1 edges and rise on the n-th.
  task automatic wait_ready_exact(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk($sformatf("ready@%0d", i), 32'(ready), (i == n) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; a1 = '0; a2 = '0;
    idle();
    step(); step();
    chk("ready_in_reset", 32'(ready), 32'd0);
    chk("rd1_in_reset", rd1, 32'h0);
    rst = 1'b0;
    wait_ready_exact(32);

    // Preload REG[5], then pulse reset and expect a full clear.
    we = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    step();
    idle(); a1 = 5'd5; #1;
    chk("preload_r5", rd1, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ready_after_rst", 32'(ready), 32'd0);
    chk("rd1_gated", rd1, 32'h0);
    wait_ready_exact(32);
    a1 = 5'd5; #1;
    chk("r5_cleared", rd1, 32'h0);
    chk("ready_nb", 32'(ready_b), 32'd1);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i); #1;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) chk($sformatf("clear_r%0d", i), rd1 | rd2, 32'h0);
      else n_cmp++;
    end

    // Write then read, and writes to x0 discarded.
    we = 1'b1; a3 = 5'd7; wd3 = 32'h12345678;
    step();
    idle(); a1 = 5'd7; #1;
    chk("rd_r7", rd1, 32'h12345678);
    we = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a2 = 5'd0; #1;
    chk("x0_bypass", rd2, 32'h0);
    step();
    idle(); #1;
    chk("x0_after", rd2, 32'h0);

    // Same-cycle bypass on both ports; non-bypass instance shows old data.
    we = 1'b1; a3 = 5'd9; wd3 = 32'hA5A5A5A5; a1 = 5'd9; a2 = 5'd9; #1;
    chk("byp_rd1", rd1, 32'hA5A5A5A5);
    chk("byp_rd2", rd2, 32'hA5A5A5A5);
    chk("nobyp_rd1", rd1_b, 32'h0);
    chk("nobyp_rd2", rd2_b, 32'h0);
    step();
    idle(); #1;
    chk("nobyp_after", rd1_b, 32'hA5A5A5A5);

    // Scoreboard set, clear by write, and set-wins collision.
    iss_en = 1'b1; iss_rd = 5'd3; a1 = 5'd3; a2 = 5'd3;
    step();
    idle(); #1;
    chk("busy_set", 32'(busy1), 32'd1);
    chk("busy_set_p2", 32'(busy2), 32'd1);
    chk("busy_set_nb", 32'(busy1_b), 32'd1);
    we = 1'b1; a3 = 5'd3; wd3 = 32'h00000011; #1;
    chk("busy_byp_clr", 32'(busy1), 32'd0);
    chk("busy_nobyp", 32'(busy1_b), 32'd1);
    step();
    idle(); #1;
    chk("busy_clr", 32'(busy1), 32'd0);
    chk("busy_clr_nb", 32'(busy1_b), 32'd0);
    iss_en = 1'b1; iss_rd = 5'd3; we = 1'b1; a3 = 5'd3; wd3 = 32'h00000022;
    step();
    idle(); #1;
    chk("collide_busy", 32'(busy1), 32'd1);
    chk("collide_data", rd1, 32'h00000022);
    iss_en = 1'b1; iss_rd = 5'd3; we = 1'b1; a3 = 5'd3; wd3 = 32'h00000033; #1;
    chk("collide_byp_busy", 32'(busy1), 32'd1);
    chk("collide_byp_data", rd1, 32'h00000033);
    idle();
    iss_en = 1'b1; iss_rd = 5'd0; a1 = 5'd0;
    step();
    idle(); #1;
    chk("busy_x0", 32'(busy1), 32'd0);

    // Writes and issues during CLEAR are ignored.
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; a3 = 5'd4; wd3 = 32'h55; iss_en = 1'b1; iss_rd = 5'd4;
    for (int i = 1; i <= 20; i++) step();
    chk("ready_mid_clear", 32'(ready), 32'd0);
    idle();
    wait_ready_exact(12);
    a1 = 5'd4; #1;
    chk("gated_rd", rd1, 32'h0);
    chk("gated_busy", 32'(busy1), 32'd0);

    // Reset at cnt=10 restarts the full sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready_exact(32);
    chk("ready_nb_final", 32'(ready_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
